// File: rtl/pool2d_engine.sv
// pool2d_engine: streams one max or average pooled value per window of a
// channel-planar feature map held in a 1-cycle-latency block RAM.
module pool2d_engine #(
  parameter int DATA_W   = 8,
  parameter int IN_W     = 26,
  parameter int IN_H     = 26,
  parameter int CHANNELS = 1,
  parameter int POOL     = 2,
  parameter int STRIDE   = 2,
  parameter int ADDR_W   = 10,
  parameter int OIDX_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic [OIDX_W-1:0] out_idx,
  output logic              valid_out,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W       = (IN_W - POOL) / STRIDE + 1;
  localparam int OUT_H       = (IN_H - POOL) / STRIDE + 1;
  localparam int K           = POOL * POOL;
  localparam int SUM_W       = DATA_W + 4;
  // Divide-by-9 as multiply by ceil(2^S/9) then shift by S; with S four
  // bits wider than the sum the rounding error never reaches the quotient.
  localparam int RECIP_SHIFT = SUM_W + 4;
  localparam int RECIP       = ((1 << RECIP_SHIFT) + 8) / 9;
  localparam int PROD_W      = SUM_W + RECIP_SHIFT;
  localparam int AVG_SHIFT   = (POOL == 4) ? 4 : 2;

  typedef enum logic [2:0] {IDLE, READ, LAST, OUT, FIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mode_q;
  logic [15:0]       win_c;
  logic [15:0]       win_oy;
  logic [15:0]       win_ox;
  logic [2:0]        ky;
  logic [2:0]        kx;
  logic [4:0]        rcnt;
  logic [SUM_W-1:0]  acc;

  logic [2:0]        nxt_ky;
  logic [2:0]        nxt_kx;
  logic [15:0]       nxt_c;
  logic [15:0]       nxt_oy;
  logic [15:0]       nxt_ox;
  logic              last_win;
  logic              last_tap;

  logic [SUM_W-1:0]  sum_final;
  logic [DATA_W-1:0] max_final;
  logic [DATA_W-1:0] avg_final;
  logic [DATA_W-1:0] result;
  logic [PROD_W-1:0] prod;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] c,
                                                input logic [15:0] oy,
                                                input logic [15:0] ox,
                                                input logic [2:0]  ky_i,
                                                input logic [2:0]  kx_i);
    int a;
    a = int'(c) * IN_W * IN_H
      + (int'(oy) * STRIDE + int'(ky_i)) * IN_W
      + int'(ox) * STRIDE + int'(kx_i);
    return ADDR_W'(a);
  endfunction

  assign valid_out = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign last_tap  = (rcnt == 5'(K - 1));

  // Next kernel tap and next window position in scan order c, oy, ox, ky, kx.
  always_comb begin
    nxt_kx = kx + 3'd1;
    nxt_ky = ky;
    if (kx == 3'(POOL - 1)) begin
      nxt_kx = 3'd0;
      nxt_ky = ky + 3'd1;
    end
    nxt_ox = win_ox + 16'd1;
    nxt_oy = win_oy;
    nxt_c  = win_c;
    if (win_ox == 16'(OUT_W - 1)) begin
      nxt_ox = 16'd0;
      nxt_oy = win_oy + 16'd1;
      if (win_oy == 16'(OUT_H - 1)) begin
        nxt_oy = 16'd0;
        nxt_c  = win_c + 16'd1;
      end
    end
    last_win = (win_c == 16'(CHANNELS - 1)) && (win_oy == 16'(OUT_H - 1)) &&
               (win_ox == 16'(OUT_W - 1));
  end

  // Fold the final sample (on rd_data during LAST) into the window result.
  always_comb begin
    sum_final = acc + SUM_W'(rd_data);
    max_final = (rd_data > acc[DATA_W-1:0]) ? rd_data : acc[DATA_W-1:0];
    prod      = PROD_W'(sum_final) * PROD_W'(RECIP);
    if (POOL == 3) begin
      avg_final = DATA_W'(prod >> RECIP_SHIFT);
    end else begin
      avg_final = DATA_W'(sum_final >> AVG_SHIFT);
    end
    result = mode_q ? avg_final : max_final;
  end

  // Next-state logic for the window sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: if (last_tap) state_nxt = LAST;
      LAST: state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = last_win ? FIN : READ;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Address generation, accumulation, result and index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= 1'b0;
      win_c    <= '0;
      win_oy   <= '0;
      win_ox   <= '0;
      ky       <= '0;
      kx       <= '0;
      rcnt     <= '0;
      acc      <= '0;
      rd_addr  <= '0;
      data_out <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            win_c   <= '0;
            win_oy  <= '0;
            win_ox  <= '0;
            ky      <= '0;
            kx      <= '0;
            rcnt    <= '0;
            rd_addr <= '0;
            out_idx <= '0;
          end
        end
        READ: begin
          if (rcnt == 5'd1) begin
            acc <= SUM_W'(rd_data);
          end else if (rcnt != 5'd0) begin
            acc <= mode_q ? sum_final : SUM_W'(max_final);
          end
          if (!last_tap) begin
            kx      <= nxt_kx;
            ky      <= nxt_ky;
            rcnt    <= rcnt + 5'd1;
            rd_addr <= addr_of(win_c, win_oy, win_ox, nxt_ky, nxt_kx);
          end
        end
        LAST: data_out <= result;
        OUT: begin
          if (out_ready) begin
            out_idx <= out_idx + OIDX_W'(1);
            if (!last_win) begin
              win_c   <= nxt_c;
              win_oy  <= nxt_oy;
              win_ox  <= nxt_ox;
              ky      <= '0;
              kx      <= '0;
              rcnt    <= '0;
              rd_addr <= addr_of(nxt_c, nxt_oy, nxt_ox, 3'd0, 3'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2d_engine.sv
// tb_pool2d_engine: drives two pooling engines (2x2/26x26 and 3x3/5x5x2)
// from block-RAM models and checks every result against a window model.
module tb_pool2d_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, mode, out_ready;
  logic [9:0] rd_addr_a, rd_addr_b, idx_a, idx_b;
  logic [7:0] rd_data_a, rd_data_b, data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  bit         sel;
  logic [9:0] cur_addr, cur_idx;
  logic [7:0] cur_data;
  logic       cur_valid, cur_busy, cur_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_max_addr;
  int obs_first, obs_second, obs_last, obs_count;

  initial forever #5 clk = ~clk;

  pool2d_engine dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .data_out(data_a),
    .out_idx(idx_a), .valid_out(valid_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a));

  pool2d_engine #(.DATA_W(8), .IN_W(5), .IN_H(5), .CHANNELS(2), .POOL(3),
                  .STRIDE(1), .ADDR_W(10), .OIDX_W(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .data_out(data_b),
    .out_idx(idx_b), .valid_out(valid_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b));

  // Block RAMs with one cycle of read latency.
  always @(posedge clk) begin
    rd_data_a <= mem_a[rd_addr_a];
    rd_data_b <= mem_b[rd_addr_b];
  end

  assign cur_addr  = sel ? rd_addr_b : rd_addr_a;
  assign cur_idx   = sel ? idx_b     : idx_a;
  assign cur_data  = sel ? data_b    : data_a;
  assign cur_valid = sel ? valid_b   : valid_a;
  assign cur_busy  = sel ? busy_b    : busy_a;
  assign cur_done  = sel ? done_b    : done_a;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window-by-window model: plain max / floor(sum/K) over the map.
  task automatic build_expected(input bit which, input bit m);
    int iw, ch, p, s, ow, a, v, mx, sum;
    iw = which ? 5 : 26;
    ch = which ? 2 : 1;
    p  = which ? 3 : 2;
    s  = which ? 1 : 2;
    ow = (iw - p) / s + 1;
    exp_q.delete();
    exp_max_addr = 0;
    for (int c = 0; c < ch; c++)
      for (int oy = 0; oy < ow; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          mx = -1;
          sum = 0;
          for (int ky = 0; ky < p; ky++)
            for (int kx = 0; kx < p; kx++) begin
              a = c * iw * iw + (oy * s + ky) * iw + ox * s + kx;
              v = which ? int'(mem_b[a]) : int'(mem_a[a]);
              if (v > mx) mx = v;
              sum += v;
              if (a > exp_max_addr) exp_max_addr = a;
            end
          exp_q.push_back(m ? sum / (p * p) : mx);
        end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, cur_valid, 0);
    checkOutput({tag, "_busy"},  cur_busy,  0);
    checkOutput({tag, "_done"},  cur_done,  0);
    checkOutput({tag, "_addr"},  cur_addr,  0);
    checkOutput({tag, "_data"},  cur_data,  0);
    checkOutput({tag, "_idx"},   cur_idx,   0);
  endtask

  // One run: style 0 = ready high, 1 = 3-cycle stall per result, 2 = random.
  task automatic applyStimulus(input bit which, input bit m, input int style,
                               input bit inject, input int abort_at);
    int k, cyc, out_cnt, prev_first, last_xfer, kk, period, max_addr, nexp;
    logic [31:0] held_d, held_i, held_a;
    bit finished;
    kk     = which ? 9 : 4;
    period = kk + 2 + ((style == 1) ? 3 : 0);
    sel    = which;
    build_expected(which, m);
    nexp   = exp_q.size();
    held_d = 0; held_i = 0; held_a = 0;
    @(negedge clk);
    mode = m;
    out_ready = 1'b1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    mode = ~m;
    checkOutput("busy_after_start", cur_busy, 1);
    checkOutput("first_addr", cur_addr, 0);
    k = 0; cyc = 0; out_cnt = 0; prev_first = 0; last_xfer = -1;
    max_addr = int'(cur_addr); finished = 0; obs_count = -1;
    while (!finished && cyc < 5000) begin
      if (int'(cur_addr) > max_addr) max_addr = int'(cur_addr);
      if (cur_done) begin
        obs_count = k;
        checkOutput("count_at_done", k, nexp);
        checkOutput("done_after_last_xfer", cyc, last_xfer + 1);
        checkOutput("busy_with_done", cur_busy, 1);
        @(negedge clk);
        checkOutput("done_width", cur_done, 0);
        checkOutput("busy_after_done", cur_busy, 0);
        finished = 1;
      end else if (cur_valid && k >= nexp) begin
        checkOutput("valid_after_last", cur_valid, 0);
        finished = 1;
      end else if (cur_valid) begin
        if (out_cnt == 0) begin
          checkOutput("data", cur_data, exp_q[k]);
          checkOutput("idx", cur_idx, k);
          if (k == 0) checkOutput("first_valid_latency", cyc, kk + 1);
          else if (style != 2) checkOutput("window_period", cyc - prev_first, period);
          prev_first = cyc;
          held_d = cur_data; held_i = cur_idx; held_a = cur_addr;
          if (k == 0) obs_first = int'(cur_data);
          if (k == 1) obs_second = int'(cur_data);
          if (k == nexp - 1) obs_last = int'(cur_data);
        end else begin
          checkOutput("hold_data", cur_data, held_d);
          checkOutput("hold_idx",  cur_idx,  held_i);
          checkOutput("hold_addr", cur_addr, held_a);
        end
      end
      if (!finished && abort_at >= 0 && k == abort_at && !cur_valid &&
          cyc == last_xfer + 3) begin
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("no_restart_busy", cur_busy, 0);
        checkOutput("no_restart_valid", cur_valid, 0);
        return;
      end
      if (!finished) begin
        if (cur_valid && k < nexp) begin
          case (style)
            1:       out_ready = (out_cnt >= 3);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
          endcase
          if (out_ready) begin
            k++;
            last_xfer = cyc;
            out_cnt = 0;
          end else begin
            out_cnt++;
          end
        end else begin
          out_ready = (style == 2) ? 1'($urandom_range(0, 1)) : (style != 1);
        end
        if (which) start_b = inject && (k == 3 || k == 7);
        else       start_a = inject && (k == 3 || k == 7);
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("run_finished", 32'(finished), 1);
    checkOutput("max_addr", max_addr, exp_max_addr);
    start_a = 1'b0;
    start_b = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic load_plan_map();
    for (int i = 0; i < 1024; i++) mem_a[i] = (i < 676) ? 8'd16 : 8'd0;
    mem_a[0] = 10;  mem_a[1] = 50;  mem_a[26] = 99; mem_a[27] = 20;
    mem_a[2] = 55;  mem_a[3] = 12;  mem_a[28] = 5;  mem_a[29] = 1;
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0; out_ready = 1'b1;
    sel = 1'b0;
    load_plan_map();
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'(i);
    #1;
    check_all_zero("reset_a");
    sel = 1'b1;
    #1;
    check_all_zero("reset_b");
    @(negedge clk);
    rst = 1'b1;

    // Max pooling with ready held high.
    applyStimulus(0, 0, 0, 0, -1);
    checkOutput("plan_max_first", obs_first, 99);
    checkOutput("plan_max_second", obs_second, 55);
    checkOutput("plan_max_count", obs_count, 169);

    // Average pooling on the same map.
    applyStimulus(0, 1, 0, 0, -1);
    checkOutput("plan_avg_first", obs_first, 44);
    checkOutput("plan_avg_second", obs_second, 18);
    checkOutput("plan_avg_last", obs_last, 16);

    // Three stalled cycles in every OUT.
    applyStimulus(0, 0, 1, 0, -1);
    checkOutput("stall_count", obs_count, 169);

    // Reset during the 10th window, then a fresh run.
    applyStimulus(0, 0, 0, 0, 9);
    applyStimulus(0, 0, 0, 0, -1);
    checkOutput("restart_first", obs_first, 99);
    checkOutput("restart_count", obs_count, 169);

    // Start pulses and mode flips while busy.
    applyStimulus(0, 0, 0, 1, -1);
    checkOutput("inject_count", obs_count, 169);

    // 3x3 average over a two-channel ramp.
    applyStimulus(1, 1, 0, 0, -1);
    checkOutput("ramp_first", obs_first, 6);
    checkOutput("ramp_last", obs_last, 43);
    checkOutput("ramp_count", obs_count, 18);

    // Random data in the 3x3 engine, with saturated and empty windows.
    for (int i = 0; i < 50; i++) mem_b[i] = 8'($urandom_range(0, 255));
    foreach (mem_b[i]) if (i < 13 && (i % 5) < 3) mem_b[i] = 8'd255;
    mem_b[37] = 0; mem_b[38] = 0; mem_b[39] = 0; mem_b[42] = 0; mem_b[43] = 0;
    mem_b[44] = 0; mem_b[47] = 0; mem_b[48] = 0; mem_b[49] = 0;
    applyStimulus(1, 1, 2, 0, -1);
    checkOutput("sat_avg_first", obs_first, 255);
    checkOutput("empty_avg_last", obs_last, 0);
    applyStimulus(1, 0, 2, 1, -1);

    // Random map in the 2x2 engine with random backpressure, both modes.
    for (int i = 0; i < 676; i++) mem_a[i] = 8'($urandom_range(0, 255));
    applyStimulus(0, 1, 2, 0, -1);
    applyStimulus(0, 0, 2, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
